// File: rtl/sal_sched_pkg.sv
// Shared types and DDR2 command encodings for the DFI command scheduler.
// Encodings are {ras_n, cas_n, we_n}; cs_n is driven separately.
package sal_sched_pkg;

    typedef enum logic [1:0] {
        CmdAct = 2'b00,
        CmdRd  = 2'b01,
        CmdWr  = 2'b10,
        CmdPre = 2'b11
    } cmd_t;

    localparam logic [2:0] RcwAct   = 3'b011;
    localparam logic [2:0] RcwRd    = 3'b101;
    localparam logic [2:0] RcwWr    = 3'b100;
    localparam logic [2:0] RcwPre   = 3'b010;
    localparam logic [2:0] RcwDesel = 3'b111;

    function automatic logic [2:0] cmd_rcw(input cmd_t cmd);
        logic [2:0] rcw;
        unique case (cmd)
            CmdAct:  rcw = RcwAct;
            CmdRd:   rcw = RcwRd;
            CmdWr:   rcw = RcwWr;
            CmdPre:  rcw = RcwPre;
            default: rcw = RcwDesel;
        endcase
        return rcw;
    endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// Round-robin arbiter: first set request at or above ptr_i, wrapping N-1 -> 0.
// N must be a power of two so the pointer addition wraps naturally.
module sal_rr_arb #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PtrW-1:0] idx_o,
    output logic            found_o
);

    logic [PtrW-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr_i + PtrW'(i);
            if (!found_o && req_i[cand]) begin
                found_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/sal_cmd_sched.sv
// Multi-bank DFI command scheduler: class-priority (CAS > ACT > PRE) round-robin arbitration
// with inter-bank tRRD/tCCD/tWTR/tRTW enforcement and a registered DFI command output.
module sal_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int unsigned BK_CNT  = 4,
    parameter int unsigned BA_W    = 2,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned TIMER_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [BK_CNT-1:0]          req_valid_i,
    input  logic [2*BK_CNT-1:0]        req_cmd_i,
    input  logic [ADDR_W*BK_CNT-1:0]   req_addr_i,
    input  logic [TIMER_W-1:0]         t_rrd_i,
    input  logic [TIMER_W-1:0]         t_ccd_i,
    input  logic [TIMER_W-1:0]         t_wtr_i,
    input  logic [TIMER_W-1:0]         t_rtw_i,
    output logic [BK_CNT-1:0]          gnt_o,
    output logic                       dfi_cs_n_o,
    output logic                       dfi_ras_n_o,
    output logic                       dfi_cas_n_o,
    output logic                       dfi_we_n_o,
    output logic [BA_W-1:0]            dfi_bank_o,
    output logic [ADDR_W-1:0]          dfi_address_o,
    output logic                       wr_issue_o,
    output logic                       rd_issue_o
);

    logic [BA_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TIMER_W-1:0] rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;

    logic               cs_n_q, cs_n_d;
    logic [2:0]         rcw_q, rcw_d;
    logic [BA_W-1:0]    bank_q, bank_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wr_iss_q, wr_iss_d, rd_iss_q, rd_iss_d;

    cmd_t               bk_cmd [BK_CNT];
    logic [BK_CNT-1:0]  cas_req, act_req, pre_req;
    logic [BK_CNT-1:0]  cas_gnt, act_gnt, pre_gnt;
    logic [BA_W-1:0]    cas_idx, act_idx, pre_idx;
    logic               cas_found, act_found, pre_found;
    logic               act_ok, rd_ok, wr_ok;

    logic [BK_CNT-1:0]  gnt_vec;
    logic [BA_W-1:0]    gnt_idx;
    logic               gnt_any;
    cmd_t               sel_cmd;
    logic [ADDR_W-1:0]  sel_addr;
    logic               iss_act, iss_rd, iss_wr;

    // Parameter t means the next same-class command may issue t cycles later; 0 and 1 are no gap.
    function automatic logic [TIMER_W-1:0] t_load(input logic [TIMER_W-1:0] t);
        return (t == '0) ? '0 : t - TIMER_W'(1);
    endfunction

    function automatic logic [TIMER_W-1:0] t_dec(input logic [TIMER_W-1:0] c);
        return (c == '0) ? '0 : c - TIMER_W'(1);
    endfunction

    assign act_ok = (rrd_q == '0);
    assign rd_ok  = (ccd_q == '0) && (wtr_q == '0);
    assign wr_ok  = (ccd_q == '0) && (rtw_q == '0);

    always_comb begin
        cas_req = '0;
        act_req = '0;
        pre_req = '0;
        for (int unsigned b = 0; b < BK_CNT; b++) begin
            bk_cmd[b]  = cmd_t'(req_cmd_i[2*b +: 2]);
            cas_req[b] = req_valid_i[b] &&
                         (((bk_cmd[b] == CmdRd) && rd_ok) || ((bk_cmd[b] == CmdWr) && wr_ok));
            act_req[b] = req_valid_i[b] && (bk_cmd[b] == CmdAct) && act_ok;
            pre_req[b] = req_valid_i[b] && (bk_cmd[b] == CmdPre);
        end
    end

    sal_rr_arb #(.N(BK_CNT), .PtrW(BA_W)) u_arb_cas (
        .req_i   (cas_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (cas_gnt),
        .idx_o   (cas_idx),
        .found_o (cas_found)
    );

    sal_rr_arb #(.N(BK_CNT), .PtrW(BA_W)) u_arb_act (
        .req_i   (act_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (act_gnt),
        .idx_o   (act_idx),
        .found_o (act_found)
    );

    sal_rr_arb #(.N(BK_CNT), .PtrW(BA_W)) u_arb_pre (
        .req_i   (pre_req),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pre_gnt),
        .idx_o   (pre_idx),
        .found_o (pre_found)
    );

    // Reset suppresses the grant so no bank sees a handshake that never reaches the bus.
    always_comb begin
        gnt_vec = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (!rst_i) begin
            if (cas_found) begin
                gnt_vec = cas_gnt;
                gnt_idx = cas_idx;
                gnt_any = 1'b1;
            end else if (act_found) begin
                gnt_vec = act_gnt;
                gnt_idx = act_idx;
                gnt_any = 1'b1;
            end else if (pre_found) begin
                gnt_vec = pre_gnt;
                gnt_idx = pre_idx;
                gnt_any = 1'b1;
            end
        end
    end

    assign gnt_o    = gnt_vec;
    assign sel_cmd  = bk_cmd[gnt_idx];
    assign sel_addr = req_addr_i[ADDR_W*gnt_idx +: ADDR_W];
    assign iss_act  = gnt_any && (sel_cmd == CmdAct);
    assign iss_rd   = gnt_any && (sel_cmd == CmdRd);
    assign iss_wr   = gnt_any && (sel_cmd == CmdWr);

    always_comb begin
        rr_ptr_d = gnt_any ? gnt_idx + BA_W'(1) : rr_ptr_q;
        rrd_d    = iss_act ? t_load(t_rrd_i) : t_dec(rrd_q);
        ccd_d    = (iss_rd || iss_wr) ? t_load(t_ccd_i) : t_dec(ccd_q);
        wtr_d    = iss_wr ? t_load(t_wtr_i) : t_dec(wtr_q);
        rtw_d    = iss_rd ? t_load(t_rtw_i) : t_dec(rtw_q);
        cs_n_d   = !gnt_any;
        rcw_d    = gnt_any ? cmd_rcw(sel_cmd) : RcwDesel;
        bank_d   = gnt_any ? gnt_idx : '0;
        addr_d   = gnt_any ? sel_addr : '0;
        wr_iss_d = iss_wr;
        rd_iss_d = iss_rd;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            rrd_q    <= '0;
            ccd_q    <= '0;
            wtr_q    <= '0;
            rtw_q    <= '0;
            cs_n_q   <= 1'b1;
            rcw_q    <= RcwDesel;
            bank_q   <= '0;
            addr_q   <= '0;
            wr_iss_q <= 1'b0;
            rd_iss_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rrd_q    <= rrd_d;
            ccd_q    <= ccd_d;
            wtr_q    <= wtr_d;
            rtw_q    <= rtw_d;
            cs_n_q   <= cs_n_d;
            rcw_q    <= rcw_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            wr_iss_q <= wr_iss_d;
            rd_iss_q <= rd_iss_d;
        end
    end

    assign dfi_cs_n_o    = cs_n_q;
    assign dfi_ras_n_o   = rcw_q[2];
    assign dfi_cas_n_o   = rcw_q[1];
    assign dfi_we_n_o    = rcw_q[0];
    assign dfi_bank_o    = bank_q;
    assign dfi_address_o = addr_q;
    assign wr_issue_o    = wr_iss_q;
    assign rd_issue_o    = rd_iss_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Directed bench for sal_cmd_sched: grant vectors checked each cycle, DFI commands checked
// against a scoreboard of expected {bank, ras/cas/we, address} entries.
module tb_sal_cmd_sched;

    localparam logic [1:0] CAct = 2'b00;
    localparam logic [1:0] CRd  = 2'b01;
    localparam logic [1:0] CWr  = 2'b10;
    localparam logic [1:0] CPre = 2'b11;

    typedef struct packed {
        logic [1:0]  bank;
        logic [2:0]  rcw;
        logic [13:0] addr;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [7:0]  req_cmd_i;
    logic [55:0] req_addr_i;
    logic [3:0]  t_rrd_i, t_ccd_i, t_wtr_i, t_rtw_i;
    logic [3:0]  gnt_o;
    logic        dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o;
    logic [1:0]  dfi_bank_o;
    logic [13:0] dfi_address_o;
    logic        wr_issue_o, rd_issue_o;

    logic        pend_v [4];
    logic [1:0]  pend_c [4];
    logic [13:0] pend_a [4];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk_i = ~clk_i;

    sal_cmd_sched u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_cmd_i     (req_cmd_i),
        .req_addr_i    (req_addr_i),
        .t_rrd_i       (t_rrd_i),
        .t_ccd_i       (t_ccd_i),
        .t_wtr_i       (t_wtr_i),
        .t_rtw_i       (t_rtw_i),
        .gnt_o         (gnt_o),
        .dfi_cs_n_o    (dfi_cs_n_o),
        .dfi_ras_n_o   (dfi_ras_n_o),
        .dfi_cas_n_o   (dfi_cas_n_o),
        .dfi_we_n_o    (dfi_we_n_o),
        .dfi_bank_o    (dfi_bank_o),
        .dfi_address_o (dfi_address_o),
        .wr_issue_o    (wr_issue_o),
        .rd_issue_o    (rd_issue_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] rcw_of(input logic [1:0] c);
        case (c)
            CAct:    return 3'b011;
            CRd:     return 3'b101;
            CWr:     return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    task automatic set_req(input int b, input logic [1:0] c, input logic [13:0] a);
        pend_v[b] = 1'b1;
        pend_c[b] = c;
        pend_a[b] = a;
    endtask

    task automatic clear_req();
        for (int b = 0; b < 4; b++) begin
            pend_v[b] = 1'b0;
            pend_c[b] = CAct;
            pend_a[b] = '0;
        end
    endtask

    task automatic drive_req();
        for (int b = 0; b < 4; b++) begin
            req_valid_i[b]         = pend_v[b];
            req_cmd_i[2*b +: 2]    = pend_c[b];
            req_addr_i[14*b +: 14] = pend_a[b];
        end
    endtask

    // One arbitration cycle: check the grant, retire the expected winner, advance past the edge.
    task automatic tick(input string tag, input logic [3:0] exp_g);
        exp_t e;
        drive_req();
        #1;
        chk(tag, 32'(gnt_o), 32'(exp_g));
        for (int b = 0; b < 4; b++) begin
            if (exp_g[b]) begin
                e.bank = 2'(b);
                e.rcw  = rcw_of(pend_c[b]);
                e.addr = pend_a[b];
                exp_q.push_back(e);
                pend_v[b] = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_end(input string tag);
        tick({tag, "_idle"}, 4'b0000);
        chk({tag, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_req();
        drive_req();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("rst_desel", 32'({dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}), 32'hf);
        chk("rst_bank_addr", 32'({dfi_bank_o, dfi_address_o}), 32'd0);
        chk("rst_strobes", 32'({wr_issue_o, rd_issue_o}), 32'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst_i === 1'b0) begin
            if (dfi_cs_n_o === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_cmd", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_bank", 32'(dfi_bank_o), 32'(mon_e.bank));
                    chk("sb_rcw", 32'({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}), 32'(mon_e.rcw));
                    chk("sb_addr", 32'(dfi_address_o), 32'(mon_e.addr));
                    chk("sb_rd_issue", 32'(rd_issue_o), 32'(mon_e.rcw == 3'b101));
                    chk("sb_wr_issue", 32'(wr_issue_o), 32'(mon_e.rcw == 3'b100));
                end
            end else begin
                chk("idle_rcw", 32'({dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}), 32'h7);
                chk("idle_strobes", 32'({wr_issue_o, rd_issue_o}), 32'd0);
            end
        end
    end

    initial begin
        rst_i   = 1'b1;
        t_rrd_i = 4'd1;
        t_ccd_i = 4'd0;
        t_wtr_i = 4'd0;
        t_rtw_i = 4'd0;
        clear_req();
        for (int b = 0; b < 4; b++) set_req(b, CAct, 14'(16'h100 + b));
        drive_req();
        #1;
        chk("rst_gnt_comb", 32'(gnt_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk("rst_hold_gnt", 32'(gnt_o), 32'd0);
            chk("rst_hold_cs_n", 32'(dfi_cs_n_o), 32'd1);
            chk("rst_hold_strobes", 32'({wr_issue_o, rd_issue_o}), 32'd0);
        end
        rst_i = 1'b0;

        // Fairness: every bank keeps an ACT queued, tRRD of 1 allows back-to-back ACTs.
        tick("fair_b0", 4'b0001); set_req(0, CAct, 14'h200);
        tick("fair_b1", 4'b0010); set_req(1, CAct, 14'h201);
        tick("fair_b2", 4'b0100); set_req(2, CAct, 14'h202);
        tick("fair_b3", 4'b1000); set_req(3, CAct, 14'h203);
        tick("fair_b0_again", 4'b0001);
        clear_req();
        idle_end("fair");

        // tRRD = 4: second ACT waits 4 cycles while a PRE slips in underneath.
        do_reset();
        t_rrd_i = 4'd4;
        set_req(0, CAct, 14'h0a0);
        set_req(1, CAct, 14'h0a1);
        tick("trrd_act_b0", 4'b0001);
        set_req(2, CPre, 14'h0400);
        tick("trrd_pre_b2", 4'b0100);
        tick("trrd_wait2", 4'b0000);
        tick("trrd_wait3", 4'b0000);
        tick("trrd_act_b1", 4'b0010);
        idle_end("trrd");

        // Class priority: CAS beats ACT beats PRE.
        do_reset();
        t_rrd_i = 4'd1;
        set_req(0, CPre, 14'h0000);
        set_req(1, CAct, 14'h1abc);
        set_req(2, CRd, 14'h0123);
        tick("prio_rd_b2", 4'b0100);
        tick("prio_act_b1", 4'b0010);
        tick("prio_pre_b0", 4'b0001);
        idle_end("prio");

        // Turnarounds: WR->RD with tWTR=6, then RD->WR with tRTW=5.
        do_reset();
        t_ccd_i = 4'd2;
        t_wtr_i = 4'd6;
        t_rtw_i = 4'd5;
        set_req(0, CWr, 14'h0010);
        set_req(1, CRd, 14'h0020);
        tick("wtr_wr_b0", 4'b0001);
        for (int i = 0; i < 5; i++) tick("wtr_gap", 4'b0000);
        tick("wtr_rd_b1", 4'b0010);
        set_req(0, CWr, 14'h0030);
        for (int i = 0; i < 4; i++) tick("rtw_gap", 4'b0000);
        tick("rtw_wr_b0", 4'b0001);
        for (int i = 0; i < 6; i++) tick("drain_timers", 4'b0000);
        // RD and WR ready together: rr_ptr=1 reaches b3 (WR) first, which re-arms tWTR against b0.
        set_req(0, CRd, 14'h0040);
        set_req(3, CWr, 14'h0050);
        tick("sim_wr_b3", 4'b1000);
        for (int i = 0; i < 5; i++) tick("sim_wtr_gap", 4'b0000);
        tick("sim_rd_b0", 4'b0001);
        idle_end("turn");

        // Reset in the middle of a tWTR countdown clears the timer.
        do_reset();
        t_wtr_i = 4'd6;
        set_req(0, CWr, 14'h0060);
        tick("mid_wr_b0", 4'b0001);
        set_req(1, CRd, 14'h0070);
        tick("mid_rd_blocked", 4'b0000);
        rst_i = 1'b1;
        tick("mid_rst_gnt", 4'b0000);
        rst_i = 1'b0;
        tick("mid_rd_after_rst", 4'b0010);
        idle_end("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
